cv32e41s_div_iter: RTL and testbench
====================================

// Module: cv32e41s_div_iter
// PURPOSE
//  Iterative signed/unsigned integer divider for RV32M DIV/DIVU/REM/REMU, width- and radix-parametrised.
//  Sits in EX beside the multiplier and is started by the decoder's div_en/div_operator.
//  Optional constant-time mode gives data-independent latency, for side-channel hardening.
//  Valid/ready on both sides; kill_i flushes an in-flight operation.
// PARAMETERS
//  DATA_W          32  operand/result width; must be a multiple of BITS_PER_CYCLE
//  BITS_PER_CYCLE  1   quotient bits retired per ITER cycle (1, 2 or 4)
//  CONST_TIME      1   1: fixed latency for all operands; 0: leading-zero skip and early exits
// PORTS
//  clk       in   1       clock
//  rst       in   1       asynchronous, active-high reset
//  valid_i   in   1       operation request
//  ready_o   out  1       divider can accept (high only in IDLE)
//  op_i      in   2       div_opcode_e: DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU
//  op_a_i    in   DATA_W  dividend
//  op_b_i    in   DATA_W  divisor
//  kill_i    in   1       abort current or pending operation
//  valid_o   out  1       result available
//  ready_i   in   1       consumer accepts result
//  result_o  out  DATA_W  quotient (DIV/DIVU) or remainder (REM/REMU)
//  busy_o    out  1       state != IDLE
// BEHAVIOUR
//  Clock and reset:
//  - One clock domain: clk. rst is asynchronous and active-high.
//  - Reset forces state=IDLE, ready_o=1, valid_o=0, busy_o=0, result_o=0 and clears internal registers.
//  Handshake:
//  - Accept on valid_i & ready_o & !kill_i. Operands and op are captured at acceptance and never re-read.
//  - valid_o stays high in DONE, with result_o stable, until valid_o & ready_i. Then state returns to IDLE.
//  - A new operation is accepted no earlier than the cycle after the result handshake.
//  FSM states IDLE -> INIT -> ITER -> DONE -> IDLE.
//  - INIT (1 cycle): take absolute values for signed ops; compute N; detect the special cases.
//    - CONST_TIME=1: N = DATA_W/BITS_PER_CYCLE.
//    - CONST_TIME=0: N = ceil((DATA_W - clz(|a|))/BITS_PER_CYCLE); N=0 when |a|=0.
//  - ITER (N cycles): restoring shift-subtract, BITS_PER_CYCLE stages per cycle. The down-counter hits 0 -> DONE.
//  - DONE: apply sign correction and the op select; assert valid_o.
//  Latency:
//  - Acceptance cycle = 0; valid_o first high in cycle N+2.
//  - Defaults: 34 cycles.
//  Sign rules (signed ops):
//  - Quotient is negated when sign(a) != sign(b).
//  - Remainder takes the sign of the dividend.
//  Special cases (RISC-V defined):
//  - b==0: quotient = all ones; remainder = a.
//  - DIV, a = -2^(DATA_W-1), b = -1: quotient = a; remainder = 0.
//  - CONST_TIME=1: special cases still take the full N iterations; the result is muxed in DONE.
//  - CONST_TIME=0: special cases skip ITER (INIT -> DONE); valid_o in cycle 2.
//  Kill:
//  - kill_i in INIT, ITER or DONE -> IDLE on the next edge. valid_o goes low that cycle and no result handshake occurs.
//  - kill_i in IDLE blocks acceptance.
//  - kill_i together with valid_o & ready_i: kill wins and the result is dropped.
//  Reset mid-operation: immediate return to the reset values above; no output is produced.
//  Assertions:
//  - ready_o implies !busy_o.
//  - valid_o implies state==DONE.
//  - result_o is stable while valid_o & !ready_i.
// TESTING
//  1. Defaults. DIVU 100/7 -> result 14, valid_o first high in cycle 34; REMU same operands -> 2.
//  2. DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIV 7/-2 -> 0xFFFFFFFD.
//  3. DIV 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//     With CONST_TIME=1, each case takes 34 cycles.
//  4. CONST_TIME=0, BITS_PER_CYCLE=2: DIVU 5/1 -> 5 in cycle 4 (N=2); b=0 -> valid_o in cycle 2.
//  5. Hold ready_i low for 5 cycles in DONE -> valid_o and result_o held, ready_o=0.
//     Then raise kill_i at ITER cycle 10 -> IDLE next cycle and valid_o never asserts.
//     Then raise rst mid-ITER -> all outputs at reset values immediately.
//  6. Back-to-back random ops across all op_i values and params {1,2,4} x {0,1}: compare to a reference model.
//     Check the N+2 latency rule and that there is no acceptance while busy_o.

Source files
------------

// File: rtl/cv32e41s_div_iter.sv
// cv32e41s_div_iter: iterative RV32M divider for DIV, DIVU, REM and REMU.
// Restoring shift-subtract retiring BITS_PER_CYCLE quotient bits per cycle.
// Ports: clk, rst (async, active-high).
//   Request: valid_i, ready_o, op_i, op_a_i, op_b_i.
//   Result:  valid_o, ready_i, result_o.
//   Control: kill_i flushes any operation; busy_o is high when not idle.
// op_i: 0 DIV, 1 DIVU, 2 REM, 3 REMU (bit0 = unsigned, bit1 = remainder).
module cv32e41s_div_iter #(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter bit CONST_TIME     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic              kill_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              busy_o
);

  localparam int NMAX = DATA_W / BITS_PER_CYCLE;
  localparam int CW   = $clog2(NMAX + 1);

  typedef enum logic [1:0] {IDLE, INIT, ITER, DONE} state_e;

  state_e            state, state_nx;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] quo, rem, dvs;
  logic [CW-1:0]     cnt;

  logic              sgn, neg_q, neg_r;
  logic              is_div0, is_ovf, skip;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W-1:0] q_fix, r_fix, res;
  logic [DATA_W-1:0] r_nx, q_nx;
  logic              carry;
  logic [CW-1:0]     n_val;
  int                lz, n_int, sh;

  assign sgn     = ~op_q[0];
  assign neg_r   = sgn & a_q[DATA_W-1];
  assign neg_q   = sgn & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
  assign a_abs   = neg_r ? -a_q : a_q;
  assign b_abs   = (sgn & b_q[DATA_W-1]) ? -b_q : b_q;
  assign is_div0 = (b_q == '0);
  assign is_ovf  = sgn & (a_q == {1'b1, {(DATA_W-1){1'b0}}})
                 & (&b_q);

  // Iteration count; the dividend is pre-aligned so that
  // its significant bits are consumed first.
  always_comb begin
    lz = DATA_W;
    for (int i = 0; i < DATA_W; i++)
      if (a_abs[i]) lz = DATA_W - 1 - i;
    if (CONST_TIME)
      n_int = NMAX;
    else
      n_int = (DATA_W - lz + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    sh    = DATA_W - n_int * BITS_PER_CYCLE;
    n_val = CW'(n_int);
  end

  assign skip = !CONST_TIME && (is_div0 || is_ovf || (n_val == '0));

  // The shifted partial remainder is DATA_W+1 bits wide;
  // its top bit is kept separately in carry.
  always_comb begin
    r_nx  = rem;
    q_nx  = quo;
    carry = 1'b0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      carry = r_nx[DATA_W-1];
      r_nx  = {r_nx[DATA_W-2:0], q_nx[DATA_W-1]};
      q_nx  = {q_nx[DATA_W-2:0], 1'b0};
      if (carry || (r_nx >= dvs)) begin
        r_nx    = r_nx - dvs;
        q_nx[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (valid_i && !kill_i) state_nx = INIT;
      INIT: begin
        if (kill_i)    state_nx = IDLE;
        else if (skip) state_nx = DONE;
        else           state_nx = ITER;
      end
      ITER: begin
        if (kill_i)             state_nx = IDLE;
        else if (cnt == CW'(1)) state_nx = DONE;
      end
      DONE: if (kill_i || ready_i) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_i && !kill_i) begin
            op_q <= op_i;
            a_q  <= op_a_i;
            b_q  <= op_b_i;
          end
        end
        INIT: begin
          quo <= a_abs << sh;
          rem <= '0;
          dvs <= b_abs;
          cnt <= n_val;
        end
        ITER: begin
          quo <= q_nx;
          rem <= r_nx;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  always_comb begin
    res = '0;
    if (op_q[1])
      res = is_div0 ? a_q : (is_ovf ? '0 : r_fix);
    else
      res = is_div0 ? '1 : (is_ovf ? a_q : q_fix);
  end

  assign ready_o  = (state == IDLE);
  assign busy_o   = (state != IDLE);
  assign valid_o  = (state == DONE);
  assign result_o = (state == DONE) ? res : '0;

  a_rdy: assert property (@(posedge clk) disable iff (rst)
    ready_o |-> !busy_o);
  a_vld: assert property (@(posedge clk) disable iff (rst)
    valid_o |-> (state == DONE));
  a_stb: assert property (@(posedge clk) disable iff (rst)
    (valid_o && !ready_i && !kill_i) |=> $stable(result_o));

endmodule

// File: tb/tb_cv32e41s_div_iter.sv
// tb_cv32e41s_div_iter: directed checks on a default divider plus
// scoreboarded random traffic on six radix/const-time variants.
module tb_cv32e41s_div_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_m = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op,
                                          input logic [31:0] a, b);
    logic sg, rm;
    sg = !op[0];
    rm = op[1];
    if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return rm ? 32'd0 : a;
    if (sg) begin
      if (rm) return $signed(a) % $signed(b);
      return $signed(a) / $signed(b);
    end
    if (rm) return a % b;
    return a / b;
  endfunction

  function automatic int ref_lat(input logic [1:0] op,
                                 input logic [31:0] a, b,
                                 input int bpc, input bit ct);
    logic [31:0] m;
    int nb;
    if (ct) return 32 / bpc + 2;
    if (b == 32'd0) return 2;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    m = (!op[0] && a[31]) ? -a : a;
    nb = 0;
    for (int i = 0; i < 32; i++) if (m[i]) nb = i + 1;
    return (nb + bpc - 1) / bpc + 2;
  endfunction

  // default-parameter divider for directed tests
  logic        m_vi, m_ro, m_ki, m_vo, m_ri, m_bo;
  logic [1:0]  m_op;
  logic [31:0] m_a, m_b, m_res;

  cv32e41s_div_iter dut (
    .clk(clk), .rst(rst_m),
    .valid_i(m_vi), .ready_o(m_ro), .op_i(m_op),
    .op_a_i(m_a), .op_b_i(m_b), .kill_i(m_ki),
    .valid_o(m_vo), .ready_i(m_ri), .result_o(m_res),
    .busy_o(m_bo)
  );

  // start at posedge+1 in IDLE; returns at posedge+1 after handshake
  task automatic do_op(input string tag, input logic [1:0] op,
                       input logic [31:0] a, b, exp, input int lat);
    int k;
    m_vi = 1'b1; m_op = op; m_a = a; m_b = b;
    @(negedge clk);
    chk({tag, "_acc"}, m_ro, 1);
    @(posedge clk); #1;
    m_vi = 1'b0; m_op = ~op; m_a = ~a; m_b = ~b;
    k = 1;
    @(negedge clk);
    while (!m_vo && k < 200) begin @(negedge clk); k++; end
    chk({tag, "_lat"}, k, lat);
    chk(tag, m_res, exp);
    @(posedge clk); #1;
  endtask

  for (genvar g = 0; g < 6; g++) begin : g_cfg
    localparam int BPC = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4);
    localparam bit CT  = (g >= 3);
    logic        vi, ro, ki, vo, ri, bo;
    logic [1:0]  op;
    logic [31:0] a, b, res;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];
    bit          seen = 1'b0;
    bit          fin = 1'b0;
    int          first;

    cv32e41s_div_iter #(
      .DATA_W(32), .BITS_PER_CYCLE(BPC), .CONST_TIME(CT)
    ) u_div (
      .clk(clk), .rst(rst),
      .valid_i(vi), .ready_o(ro), .op_i(op),
      .op_a_i(a), .op_b_i(b), .kill_i(ki),
      .valid_o(vo), .ready_i(ri), .result_o(res),
      .busy_o(bo)
    );

    always @(posedge clk) begin
      #1;
      ri = ($urandom_range(0, 3) != 0);
    end

    initial begin
      int n;
      vi = 1'b0; ki = 1'b0; op = '0; a = '0; b = '0;
      wait (!rst);
      @(posedge clk); #1;
      for (int i = 0; i < 40; i++) begin
        if (i == 0) begin
          op = 2'd1; a = 32'd5; b = 32'd1;
        end else if (i == 1) begin
          op = 2'd1; a = 32'h1234; b = 32'd0;
        end else begin
          op = 2'($urandom_range(0, 3));
          a = $urandom >> $urandom_range(0, 31);
          b = $urandom >> $urandom_range(0, 31);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
          case ($urandom_range(0, 9))
            0: b = '0;
            1: begin a = 32'h8000_0000; b = '1; end
            2: a = '0;
            default: ;
          endcase
        end
        vi = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ro && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk($sformatf("g%0d_acc_to", g), n, 0);
        exp_q.push_back(ref_res(op, a, b));
        lat_q.push_back(ref_lat(op, a, b, BPC, CT));
        acc_q.push_back(cyc);
        @(posedge clk); #1;
        vi = 1'b0; a = ~a; b = ~b;
      end
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
        @(negedge clk); n++;
      end
      chk($sformatf("g%0d_drain", g), exp_q.size(), 0);
      fin = 1'b1;
    end

    always @(negedge clk) begin
      if (!rst) begin
        if (vi && bo) chk($sformatf("g%0d_busy_rdy", g), ro, 0);
        if (vo && !seen) begin
          seen = 1'b1;
          first = cyc;
        end
        if (vo && ri) begin
          if (exp_q.size() == 0)
            chk($sformatf("g%0d_sb_extra", g), exp_q.size(), 1);
          else begin
            chk($sformatf("g%0d_res", g), res, exp_q.pop_front());
            chk($sformatf("g%0d_lat", g), first - acc_q.pop_front(),
                lat_q.pop_front());
          end
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int k, vcnt, n;
    m_vi = 1'b0; m_ki = 1'b0; m_op = '0; m_a = '0; m_b = '0;
    m_ri = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", m_ro, 1);
    chk("rst_valid", m_vo, 0);
    chk("rst_busy", m_bo, 0);
    chk("rst_result", m_res, 0);
    rst = 1'b0;
    rst_m = 1'b0;

    do_op("divu", 2'd1, 32'd100, 32'd7, 32'd14, 34);
    do_op("remu", 2'd3, 32'd100, 32'd7, 32'd2, 34);
    do_op("div_n7_2", 2'd0, -32'sd7, 32'd2, 32'hFFFF_FFFD, 34);
    do_op("rem_n7_2", 2'd2, -32'sd7, 32'd2, 32'hFFFF_FFFF, 34);
    do_op("div_7_n2", 2'd0, 32'd7, -32'sd2, 32'hFFFF_FFFD, 34);
    do_op("div_by0", 2'd0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 34);
    do_op("rem_by0", 2'd2, 32'h1234, 32'd0, 32'h1234, 34);
    do_op("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, 34);
    do_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

    // result held while consumer stalls
    m_ri = 1'b0;
    m_vi = 1'b1; m_op = 2'd1; m_a = 32'd100; m_b = 32'd7;
    @(posedge clk); #1;
    m_vi = 1'b0;
    k = 1;
    @(negedge clk);
    while (!m_vo && k < 200) begin @(negedge clk); k++; end
    chk("hold_lat", k, 34);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", m_vo, 1);
      chk("hold_res", m_res, 14);
      chk("hold_ready", m_ro, 0);
      @(negedge clk);
    end
    m_ri = 1'b1;
    @(negedge clk);
    chk("hold_rel_valid", m_vo, 0);
    chk("hold_rel_ready", m_ro, 1);
    @(posedge clk); #1;

    // kill in ITER cycle 10
    m_vi = 1'b1; m_op = 2'd0; m_a = 32'd1000; m_b = 32'd3;
    @(posedge clk); #1;
    m_vi = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("kill_pre_busy", m_bo, 1);
    m_ki = 1'b1;
    @(posedge clk); #1;
    m_ki = 1'b0;
    chk("kill_ready", m_ro, 1);
    chk("kill_busy", m_bo, 0);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_vo) vcnt++;
    end
    chk("kill_no_valid", vcnt, 0);
    @(posedge clk); #1;

    // kill while idle blocks acceptance
    m_vi = 1'b1; m_ki = 1'b1;
    @(posedge clk); #1;
    m_vi = 1'b0; m_ki = 1'b0;
    chk("kill_idle_busy", m_bo, 0);

    // kill beats the result handshake
    m_ri = 1'b0;
    m_vi = 1'b1; m_op = 2'd1; m_a = 32'd100; m_b = 32'd7;
    @(posedge clk); #1;
    m_vi = 1'b0;
    k = 1;
    @(negedge clk);
    while (!m_vo && k < 200) begin @(negedge clk); k++; end
    chk("killw_lat", k, 34);
    m_ki = 1'b1; m_ri = 1'b1;
    @(posedge clk); #1;
    m_ki = 1'b0;
    chk("killw_valid", m_vo, 0);
    chk("killw_ready", m_ro, 1);

    // asynchronous reset mid-ITER
    m_vi = 1'b1; m_op = 2'd3; m_a = 32'd100; m_b = 32'd7;
    @(posedge clk); #1;
    m_vi = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("arst_pre_busy", m_bo, 1);
    rst_m = 1'b1;
    #1;
    chk("arst_ready", m_ro, 1);
    chk("arst_valid", m_vo, 0);
    chk("arst_busy", m_bo, 0);
    chk("arst_result", m_res, 0);
    @(posedge clk); #1;
    rst_m = 1'b0;
    do_op("post_rst", 2'd1, 32'd100, 32'd7, 32'd14, 34);

    n = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin &&
             g_cfg[3].fin && g_cfg[4].fin && g_cfg[5].fin) &&
           n < 20000) begin
      @(negedge clk); n++;
    end
    chk("cfg_timeout", (n < 20000), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
